// File: rtl/score_display_pkg.sv
// Shared types and constants for the score display slice.
// Contents: seg_t (active-low {g,f,e,d,c,b,a}), digit_idx_t,
//           SEG_BLANK and SEG_DIGIT[0:9] decode constants, width localparams.
package score_display_pkg;

  localparam int unsigned NIBBLE_W = 4;
  localparam int unsigned DIGITS   = 4;
  localparam int unsigned BCD_W    = NIBBLE_W * DIGITS;
  localparam int unsigned SEG_W    = 7;

  typedef logic [SEG_W-1:0] seg_t;
  typedef logic [1:0]       digit_idx_t;

  localparam seg_t SEG_BLANK = 7'b1111111;

  // Active-low segment patterns for decimal digits 0..9.
  localparam seg_t SEG_DIGIT [0:9] = '{
    7'b1000000,  // 0
    7'b1111001,  // 1
    7'b0100100,  // 2
    7'b0110000,  // 3
    7'b0011001,  // 4
    7'b0010010,  // 5
    7'b0000010,  // 6
    7'b1111000,  // 7
    7'b0000000,  // 8
    7'b0010000   // 9
  };

endpackage

// File: rtl/bcd_to_seg.sv
// Combinational BCD nibble to active-low seven-segment decode.
// Ports: nibble (4-bit BCD digit in), seg_c (segments out; 10..15 decode blank).
module bcd_to_seg
  import score_display_pkg::*;
(
  input  logic [NIBBLE_W-1:0] nibble,
  output seg_t                seg_c
);

  always_comb begin
    seg_c = SEG_BLANK;
    case (nibble)
      4'd0:    seg_c = SEG_DIGIT[0];
      4'd1:    seg_c = SEG_DIGIT[1];
      4'd2:    seg_c = SEG_DIGIT[2];
      4'd3:    seg_c = SEG_DIGIT[3];
      4'd4:    seg_c = SEG_DIGIT[4];
      4'd5:    seg_c = SEG_DIGIT[5];
      4'd6:    seg_c = SEG_DIGIT[6];
      4'd7:    seg_c = SEG_DIGIT[7];
      4'd8:    seg_c = SEG_DIGIT[8];
      4'd9:    seg_c = SEG_DIGIT[9];
      default: seg_c = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/score_display.sv
// Four-digit multiplexed common-anode display driver for the packed-BCD score,
// with leading-zero blanking, a high-score register updated at game over,
// current/high score select and blinking while game_over is high.
// Ports: clk, reset (sync, active high), score[15:0] BCD, game_over, show_high,
//        an[3:0] anodes (active low, an[0]=ones), seg[6:0] {g..a} active low,
//        dp active low, high_score[15:0] BCD best score since reset.
module score_display
  import score_display_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned BLINK_DIV   = 50000000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [BCD_W-1:0] score,
  input  logic             game_over,
  input  logic             show_high,
  output logic [DIGITS-1:0] an,
  output seg_t             seg,
  output logic             dp,
  output logic [BCD_W-1:0] high_score
);

  localparam int unsigned REF_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned BLK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [REF_W-1:0] REF_MAX = REF_W'(REFRESH_DIV - 1);
  localparam logic [BLK_W-1:0] BLK_MAX = BLK_W'(BLINK_DIV - 1);

  logic [REF_W-1:0]  ref_cnt_q, ref_cnt_d;
  digit_idx_t        idx_q, idx_d;
  logic [BLK_W-1:0]  blink_cnt_q, blink_cnt_d;
  logic              phase_off_q, phase_off_d;
  logic              prev_go_q, prev_go_d;
  logic [BCD_W-1:0]  hs_q, hs_d;
  logic [DIGITS-1:0] an_q, an_d;
  seg_t              seg_q, seg_d;
  logic              dp_q, dp_d;

  logic [BCD_W-1:0]    disp_c;
  logic [NIBBLE_W-1:0] nibble_c;
  logic                blank_digit_c;
  logic                lit_c;
  seg_t                seg_dec_c;

  // Value being shown and the nibble/blanking for the active digit.
  always_comb begin
    disp_c        = show_high ? hs_q : score;
    nibble_c      = disp_c[3:0];
    blank_digit_c = 1'b0;
    case (idx_q)
      2'd0: begin
        nibble_c      = disp_c[3:0];
        blank_digit_c = 1'b0;
      end
      2'd1: begin
        nibble_c      = disp_c[7:4];
        blank_digit_c = (disp_c[15:4] == 12'h000);
      end
      2'd2: begin
        nibble_c      = disp_c[11:8];
        blank_digit_c = (disp_c[15:8] == 8'h00);
      end
      default: begin
        nibble_c      = disp_c[15:12];
        blank_digit_c = (disp_c[15:12] == 4'h0);
      end
    endcase
    // Blink-off only applies while game_over is still high, so dropping it
    // relights the display on the very next registered output.
    lit_c = ~blank_digit_c & ~(game_over & phase_off_q);
  end

  bcd_to_seg u_bcd_to_seg (
    .nibble (nibble_c),
    .seg_c  (seg_dec_c)
  );

  // Next-state for scan, blink, high score and registered pin outputs.
  always_comb begin
    ref_cnt_d   = ref_cnt_q + REF_W'(1);
    idx_d       = idx_q;
    blink_cnt_d = '0;
    phase_off_d = 1'b0;
    prev_go_d   = game_over;
    hs_d        = hs_q;
    an_d        = 4'b1111;
    seg_d       = SEG_BLANK;
    dp_d        = 1'b1;

    if (ref_cnt_q == REF_MAX) begin
      ref_cnt_d = '0;
      idx_d     = idx_q + digit_idx_t'(1);
    end

    if (game_over) begin
      blink_cnt_d = blink_cnt_q + BLK_W'(1);
      phase_off_d = phase_off_q;
      if (blink_cnt_q == BLK_MAX) begin
        blink_cnt_d = '0;
        phase_off_d = ~phase_off_q;
      end
    end

    // Packed BCD orders the same as binary, so a plain compare suffices.
    if (game_over && !prev_go_q && (score > hs_q)) begin
      hs_d = score;
    end

    if (lit_c) begin
      an_d  = ~(4'b0001 << idx_q);
      seg_d = seg_dec_c;
      dp_d  = ~(show_high && (idx_q == 2'd3));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ref_cnt_q   <= '0;
      idx_q       <= '0;
      blink_cnt_q <= '0;
      phase_off_q <= 1'b0;
      prev_go_q   <= 1'b0;
      hs_q        <= '0;
      an_q        <= 4'b1111;
      seg_q       <= SEG_BLANK;
      dp_q        <= 1'b1;
    end else begin
      ref_cnt_q   <= ref_cnt_d;
      idx_q       <= idx_d;
      blink_cnt_q <= blink_cnt_d;
      phase_off_q <= phase_off_d;
      prev_go_q   <= prev_go_d;
      hs_q        <= hs_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
      dp_q        <= dp_d;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign high_score = hs_q;

endmodule

// File: tb/tb_score_display.sv
// Directed self-checking bench for score_display (REFRESH_DIV=4, BLINK_DIV=16).
module tb_score_display;

  logic        clk;
  logic        reset;
  logic [15:0] score;
  logic        game_over;
  logic        show_high;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic [15:0] high_score;

  int n_chk;
  int n_pass;
  int cyc;

  score_display #(
    .REFRESH_DIV (4),
    .BLINK_DIV   (16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .score      (score),
    .game_over  (game_over),
    .show_high  (show_high),
    .an         (an),
    .seg        (seg),
    .dp         (dp),
    .high_score (high_score)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s cyc=%0d: got %h expected %h", tag, cyc, got, exp);
  endtask

  // {an, seg} per scan slot
  logic [10:0] exp_0120 [4];
  logic [10:0] exp_0000 [4];
  // {an, seg, dp} per scan slot for high score 1234
  logic [11:0] exp_1234 [4];

  initial begin
    exp_0120[0] = {4'b1110, 7'b1000000};
    exp_0120[1] = {4'b1101, 7'b0100100};
    exp_0120[2] = {4'b1011, 7'b1111001};
    exp_0120[3] = {4'b1111, 7'b1111111};
    exp_0000[0] = {4'b1110, 7'b1000000};
    exp_0000[1] = {4'b1111, 7'b1111111};
    exp_0000[2] = {4'b1111, 7'b1111111};
    exp_0000[3] = {4'b1111, 7'b1111111};
    exp_1234[0] = {4'b1110, 7'b0011001, 1'b1};
    exp_1234[1] = {4'b1101, 7'b0110000, 1'b1};
    exp_1234[2] = {4'b1011, 7'b0100100, 1'b1};
    exp_1234[3] = {4'b0111, 7'b1111001, 1'b0};

    n_chk = 0; n_pass = 0; cyc = 0;
    clk = 1'b0; reset = 1'b1; score = 16'h0120; game_over = 1'b0; show_high = 1'b0;

    // Reset values
    repeat (3) begin
      step();
      check("reset_state", 32'({an, seg, dp, high_score}), 32'({4'hF, 7'h7F, 1'b1, 16'h0000}));
    end
    reset = 1'b0;
    cyc = 0;

    // Scan of 0120: digit 3 blanked
    for (int s = 0; s < 4; s++) begin
      for (int r = 0; r < 4; r++) begin
        step();
        check("scan_0120", 32'({an, seg}), 32'(exp_0120[s]));
      end
    end

    // Zero score: only ones digit lit
    score = 16'h0000;
    for (int s = 0; s < 4; s++) begin
      for (int r = 0; r < 4; r++) begin
        step();
        check("scan_0000", 32'({an, seg}), 32'(exp_0000[s]));
      end
    end

    // Non-BCD nibble on ones digit decodes blank but the anode stays on
    score = 16'h000A;
    for (int r = 0; r < 4; r++) begin
      step();
      check("ones_nibble_a", 32'({an, seg}), 32'({4'b1110, 7'b1111111}));
    end
    repeat (12) step();

    // High score: load on rising edge
    score = 16'h0350;
    game_over = 1'b1;
    check("hs_before_edge", 32'(high_score), 32'h0000);
    step();
    check("hs_load_0350", 32'(high_score), 32'h0350);
    repeat (3) step();
    game_over = 1'b0;
    score = 16'h0200;
    repeat (2) step();
    game_over = 1'b1;
    step();
    check("hs_lower_score", 32'(high_score), 32'h0350);
    step();
    score = 16'h0360;
    repeat (4) step();
    check("hs_held_go", 32'(high_score), 32'h0350);
    game_over = 1'b0;
    repeat (2) step();

    // Blink: all digits lit with 1111 so lit <=> an != 1111
    score = 16'h1111;
    step();
    game_over = 1'b1;
    for (int j = 1; j <= 36; j++) begin
      step();
      check("blink_phase", 32'(an == 4'b1111), 32'((j >= 17) && (j <= 32)));
    end
    repeat (14) step();
    check("blink_off_again", 32'(an), 32'h0000000F);
    game_over = 1'b0;
    step();
    check("blink_drop_lit", 32'(an != 4'b1111), 32'd1);
    check("hs_load_1111", 32'(high_score), 32'h1111);

    // Load 1234 and show high score
    score = 16'h1234;
    game_over = 1'b1;
    step();
    check("hs_load_1234", 32'(high_score), 32'h1234);
    game_over = 1'b0;
    show_high = 1'b1;
    score = 16'h0000;
    step();
    for (int k = 0; k < 16; k++) begin
      if ((cyc % 16) != 0) step();
    end
    for (int s = 0; s < 4; s++) begin
      for (int r = 0; r < 4; r++) begin
        if (!((s == 3) && (r >= 2))) begin
          step();
          check("show_high_1234", 32'({an, seg, dp}), 32'(exp_1234[s]));
        end
      end
    end

    // Reset during the thousands slot
    reset = 1'b1;
    step();
    check("reset_mid_scan", 32'({an, seg, dp, high_score}), 32'({4'hF, 7'h7F, 1'b1, 16'h0000}));
    reset = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
